lcd_nibble_tx: RTL and testbench
================================

Name: lcd_nibble_tx

Overview:
- Physical-layer stage directly below the LCD init/text sequencers.
- Accepts one 5-bit command: bit4 = RS, bits3:0 = data nibble. Drives it onto the 4-bit LCD bus, generates one timed E strobe, then waits a caller-supplied post-command delay.
- Reports completion with a one-cycle commandDone pulse.
- Upstream holds sendCommand high while it has work. The guard interval lets its registered command/delay update before the next sample.

Parameters:
- T_SETUP_CYC, 2: cycles LCD_D is stable with E low before E rises (40 ns at 50 MHz).
- T_PULSE_CYC, 12: cycles E is high (240 ns at 50 MHz). Must be >= 1.
- T_HOLD_CYC, 1: cycles LCD_D is held with E low after E falls.
- GUARD_CYC, 2: cycles after commandDone during which sendCommand is ignored.
- DELAY_W, 21: width of commandDelay and the wait counter.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- sendCommand  in  1  request. Level-sensitive, sampled only in IDLE.
- command  in  5  {RS, nibble}. Latched on accept.
- commandDelay  in  DELAY_W  post-strobe wait in CLK cycles. Latched on accept.
- commandDone  out  1  registered one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- LCD_D  out  5  registered {RS, D7..D4} to the panel.
- LCD_E  out  1  registered enable strobe.

Behaviour:
- Reset is asynchronous on RST_N low:
  - state = IDLE; LCD_D = 0, LCD_E = 0, commandDone = 0, busy = 0; all counters = 0.
  - Reset mid-transfer drops LCD_E immediately, no commandDone is issued, and the latched command is discarded.
- States: IDLE, SETUP, PULSE, HOLD, WAIT, DONE, GUARD. A single down-counter of width max(DELAY_W, 8) is shared across states.
- Timing reference: "edge 0" is the rising edge at which IDLE samples sendCommand = 1.
  - At edge 0: cmd_reg <= command, dly_reg <= commandDelay, LCD_D <= command, state -> SETUP.
- SETUP: LCD_E = 0 for T_SETUP_CYC cycles (edges 0 .. T_SETUP_CYC-1), then PULSE.
  - If T_SETUP_CYC = 0, go straight to PULSE; E then rises at edge 1, because LCD_D must be registered first.
- PULSE: LCD_E = 1 for exactly T_PULSE_CYC cycles, then HOLD.
- HOLD: LCD_E = 0, LCD_D unchanged for T_HOLD_CYC cycles, then WAIT.
- WAIT: counts dly_reg cycles. If dly_reg = 0, WAIT is skipped and DONE follows HOLD directly.
- DONE: commandDone = 1 for exactly one cycle, then GUARD.
  - Overall: with S, P, H and delay D, commandDone is high in the cycle after edge S+P+H+D.
  - Defaults: D + 15.
- GUARD: GUARD_CYC cycles with sendCommand ignored, then IDLE. The next accept is possible no earlier than GUARD_CYC+1 cycles after commandDone.
- LCD_D holds the last driven value in all states, including IDLE after completion. It changes only on accept.
- While busy, changes on command, commandDelay or sendCommand have no effect:
  - Deasserting sendCommand mid-transfer does not abort the transfer.
  - A request held high continuously produces back-to-back transfers separated by DONE + GUARD.
- No arithmetic overflow: counters only decrement to 0 and are reloaded at state entry. commandDelay = 2^DELAY_W-1 must complete correctly.
- LCD_E is never high outside PULSE. No glitches: all outputs are flops.

Test Plan:
- Reset then single command: command = 5'b00011, delay = 5000, defaults.
  - LCD_D = 00011 from edge 0; LCD_E high for exactly 12 cycles, starting at edge 2.
  - commandDone is one cycle, after edge 5015; busy falls 3 cycles later.
- Zero delay: command = 5'b10100, delay = 0.
  - commandDone after edge 15; LCD_D stays 10100 while idle afterwards.
- Held request: sendCommand held high, with command/delay updated 2 cycles after each commandDone.
  - 14 transfers, each latching the updated value; never the stale one.
- Mid-transfer stimulus changes: change command to 5'b01111 and drop sendCommand during PULSE.
  - LCD_D keeps the original value; commandDone still fires on schedule.
- Async reset: pull RST_N low during PULSE.
  - LCD_E = 0 and busy = 0 within the same cycle, without a clock edge; no commandDone.
  - After release, IDLE accepts a new command normally.
- Maximum delay: commandDelay = 21'h1FFFFF.
  - commandDone after edge 15 + 2097151; no early wrap.

Source files
------------

// File: rtl/lcd_nibble_tx.sv
// Purpose: drives one {RS, nibble} command onto the 4-bit LCD bus with a timed E strobe, then waits a post-command delay.
// Latency: commandDone rises at edge T_SETUP_CYC+T_PULSE_CYC+T_HOLD_CYC+commandDelay after accept (15+delay at defaults).
// Backpressure: sendCommand is a level request sampled only in IDLE; busy covers the whole transfer plus the guard interval.
//
// Ports:
//   CLK, RST_N    clock and asynchronous active-low reset
//   sendCommand   level request, sampled only while idle
//   command       {RS, D7..D4}, latched on accept
//   commandDelay  post-strobe wait in CLK cycles, latched on accept
//   commandDone   one-cycle completion pulse
//   busy          high in every state except IDLE
//   LCD_D, LCD_E  registered panel bus and enable strobe
module lcd_nibble_tx #(
    parameter int T_SETUP_CYC = 2,
    parameter int T_PULSE_CYC = 12,
    parameter int T_HOLD_CYC  = 1,
    parameter int GUARD_CYC   = 2,
    parameter int DELAY_W     = 21
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               sendCommand,
    input  logic [4:0]         command,
    input  logic [DELAY_W-1:0] commandDelay,
    output logic               commandDone,
    output logic               busy,
    output logic [4:0]         LCD_D,
    output logic               LCD_E
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        DONE,
        GUARD
    } state_t;

    localparam int CNT_W = (DELAY_W > 8) ? DELAY_W : 8;

    // Every timed state lasts N cycles: the counter is loaded with N-1 on
    // entry and the state is left at the edge that sees it at zero.
    // A zero setup still spends one cycle in SETUP so LCD_D is registered
    // one edge before E rises.
    localparam logic [CNT_W-1:0] SETUP_LOAD = (T_SETUP_CYC > 1) ? CNT_W'(T_SETUP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] PULSE_LOAD = (T_PULSE_CYC > 1) ? CNT_W'(T_PULSE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = (T_HOLD_CYC  > 1) ? CNT_W'(T_HOLD_CYC  - 1) : '0;
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYC   > 1) ? CNT_W'(GUARD_CYC   - 1) : '0;

    state_t             state;
    state_t             stateNext;
    state_t             afterHold;
    state_t             afterPulse;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntNext;
    logic [DELAY_W-1:0] dlyReg;
    logic [CNT_W-1:0]   dlyExt;

    assign dlyExt = CNT_W'(dlyReg);

    always_comb begin
        stateNext  = state;
        cntNext    = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        // Zero-length HOLD / WAIT phases are skipped entirely.
        afterHold  = (dlyReg != '0) ? WAIT : DONE;
        afterPulse = (T_HOLD_CYC > 0) ? HOLD : afterHold;

        case (state)
            IDLE:    if (sendCommand) stateNext = SETUP;
            SETUP:   if (cnt == '0) stateNext = PULSE;
            PULSE:   if (cnt == '0) stateNext = afterPulse;
            HOLD:    if (cnt == '0) stateNext = afterHold;
            WAIT:    if (cnt == '0) stateNext = DONE;
            DONE:    stateNext = (GUARD_CYC > 0) ? GUARD : IDLE;
            GUARD:   if (cnt == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Reload on state entry; the down-counter never wraps because it
        // only decrements while nonzero.
        if (stateNext != state) begin
            case (stateNext)
                SETUP:   cntNext = SETUP_LOAD;
                PULSE:   cntNext = PULSE_LOAD;
                HOLD:    cntNext = HOLD_LOAD;
                WAIT:    cntNext = dlyExt - CNT_W'(1);
                GUARD:   cntNext = GUARD_LOAD;
                default: cntNext = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Outputs are decoded from the next state so they are flops aligned
    // with the state they belong to.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LCD_D       <= '0;
            LCD_E       <= 1'b0;
            commandDone <= 1'b0;
            busy        <= 1'b0;
            dlyReg      <= '0;
        end else begin
            LCD_E       <= (stateNext == PULSE);
            commandDone <= (stateNext == DONE);
            busy        <= (stateNext != IDLE);
            // LCD_D doubles as the latched command; it only moves on accept.
            if (state == IDLE && sendCommand) begin
                LCD_D  <= command;
                dlyReg <= commandDelay;
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
module tb_lcd_nibble_tx;

    // Narrower delay so the all-ones delay case stays within a short run.
    localparam int DW = 14;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          sendCommand;
    logic [4:0]    command;
    logic [DW-1:0] commandDelay;
    logic          commandDone;
    logic          busy;
    logic [4:0]    LCD_D;
    logic          LCD_E;

    lcd_nibble_tx #(.DELAY_W(DW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .sendCommand  (sendCommand),
        .command      (command),
        .commandDelay (commandDelay),
        .commandDone  (commandDone),
        .busy         (busy),
        .LCD_D        (LCD_D),
        .LCD_E        (LCD_E)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] cmd;
        int         rise;
        int         done;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // cyc equals the index of the most recent rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected timing at defaults: E rises at edge a+2, done at a+15+delay.
    task automatic pushExp(input logic [4:0] c, input logic [DW-1:0] d, input int a);
        exp_t e;
        e.cmd  = c;
        e.rise = a + 2;
        e.done = a + 15 + int'(d);
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; leaves sendCommand high.
    task automatic issue(input logic [4:0] c, input logic [DW-1:0] d, output int a);
        command      = c;
        commandDelay = d;
        sendCommand  = 1'b1;
        a = cyc + 1;
        pushExp(c, d, a);
        @(negedge CLK);
        check("accept_lcd_d", LCD_D, c);
        check("accept_busy", busy, 1);
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    // Output monitor: E strobe shape and commandDone against the scoreboard.
    logic prevE    = 1'b0;
    logic prevDone = 1'b0;
    int   eLen     = 0;
    exp_t got;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prevE    = 1'b0;
            prevDone = 1'b0;
            eLen     = 0;
        end else begin
            if (LCD_E && !prevE) begin
                eLen = 1;
                check("e_rise_expected", sb.size() > 0, 1);
                if (sb.size() > 0) check("e_rise_edge", cyc, sb[0].rise);
            end else if (LCD_E) begin
                eLen++;
            end
            if (!LCD_E && prevE) check("e_width", eLen, 12);
            if (commandDone) begin
                check("done_single_cycle", prevDone, 0);
                check("done_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check("done_edge", cyc, got.done);
                    check("done_lcd_d", LCD_D, got.cmd);
                end
            end
            prevE    = LCD_E;
            prevDone = commandDone;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int x;
        logic [4:0]    c;
        logic [DW-1:0] d;

        RST_N        = 1'b0;
        sendCommand  = 1'b0;
        command      = '0;
        commandDelay = '0;
        repeat (3) @(negedge CLK);
        check("reset_lcd_d", LCD_D, 0);
        check("reset_lcd_e", LCD_E, 0);
        check("reset_busy", busy, 0);
        check("reset_done", commandDone, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single command, delay 5000.
        issue(5'b00011, 14'd5000, a);
        sendCommand = 1'b0;
        check("setup_e_low0", LCD_E, 0);
        waitUntil(a + 1);
        check("setup_e_low1", LCD_E, 0);
        waitUntil(a + 2);
        check("pulse_e_high", LCD_E, 1);
        x = a + 15 + 5000;
        waitUntil(x + 2);
        check("busy_before_fall", busy, 1);
        waitUntil(x + 3);
        check("busy_fall", busy, 0);

        // Zero delay; LCD_D holds while idle.
        waitUntil(x + 4);
        issue(5'b10100, 14'd0, a);
        sendCommand = 1'b0;
        x = a + 15;
        waitUntil(x + 10);
        check("idle_lcd_d_hold", LCD_D, 5'b10100);
        check("idle_busy", busy, 0);

        // Held request: 14 back-to-back transfers, inputs updated 2 cycles after each done.
        waitUntil(x + 11);
        c = 5'd1;
        d = '0;
        issue(c, d, a);
        for (int k = 0; k < 14; k++) begin
            x = a + 15 + int'(d);
            waitUntil(x + 2);
            if (k < 13) begin
                c = 5'((k + 1) * 3 + 1);
                d = DW'((k + 1) * 5);
                command      = c;
                commandDelay = d;
                a = x + 4;
                pushExp(c, d, a);
            end else begin
                sendCommand = 1'b0;
            end
        end
        waitUntil(x + 6);
        check("held_stops", busy, 0);
        check("held_last_lcd_d", LCD_D, c);

        // Mid-transfer changes are ignored.
        issue(5'b00110, 14'd20, a);
        waitUntil(a + 5);
        check("mid_e_high", LCD_E, 1);
        command      = 5'b01111;
        commandDelay = 14'd3;
        sendCommand  = 1'b0;
        waitUntil(a + 10);
        check("mid_lcd_d", LCD_D, 5'b00110);
        x = a + 35;
        waitUntil(x + 6);
        check("mid_no_rerun", busy, 0);
        check("mid_lcd_d_after", LCD_D, 5'b00110);

        // Asynchronous reset during PULSE.
        issue(5'b11001, 14'd30, a);
        sendCommand = 1'b0;
        waitUntil(a + 5);
        check("rst_e_high_before", LCD_E, 1);
        #2 RST_N = 1'b0;
        #1;
        check("rst_async_e", LCD_E, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", commandDone, 0);
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        check("rst_lcd_d", LCD_D, 0);
        waitUntil(a + 60);
        check("rst_stays_idle", busy, 0);
        issue(5'b01010, 14'd7, a);
        sendCommand = 1'b0;
        waitUntil(a + 15 + 7 + 4);
        check("post_rst_idle", busy, 0);

        // Maximum delay.
        issue(5'b10001, '1, a);
        sendCommand = 1'b0;
        x = a + 15 + 16383;
        waitUntil(x - 1);
        check("max_no_early", busy, 1);
        waitUntil(x + 4);
        check("max_idle", busy, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
